// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: accumulates one row of partial sums from the PE datapath
// over several filter/channel passes. It streams the completed sums to the
// output buffer on the final pass, honouring outbuf_full back-pressure.
module psum_accum_ctrl #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_LEN   = 4,
  parameter int DEPTH      = 16,
  parameter int PASS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_LEN:0]     num_psums,
  input  logic [PASS_WIDTH-1:0] num_passes,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  outbuf_full,
  output logic                  outbuf_write,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_LEN:0]     C_DEPTH = (ADDR_LEN + 1)'(DEPTH);
  localparam logic [ADDR_LEN:0]     C_N_ONE = (ADDR_LEN + 1)'(1);
  localparam logic [PASS_WIDTH-1:0] C_P_ONE = PASS_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  // Adder used for every accumulation: plain unsigned add that wraps
  // modulo 2**DATA_WIDTH (no saturation, no carry out).
  function automatic logic [DATA_WIDTH-1:0] wrap_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_LEN-1:0]   r_idx;
  logic [PASS_WIDTH-1:0] r_pass;
  logic [ADDR_LEN:0]     r_n;
  logic [PASS_WIDTH-1:0] r_p;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_out_q;

  logic [ADDR_LEN:0]     w_n_start;
  logic [PASS_WIDTH-1:0] w_p_start;
  logic                  w_last_pass;
  logic                  w_last_idx;
  logic                  w_in_ready;
  logic                  w_xfer;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_mem_rd;
  logic [DATA_WIDTH-1:0] w_sum;

  // Row geometry as it will be latched: N clamped to the register-file
  // depth, and a pass count of zero treated as a single pass.
  assign w_n_start = (num_psums > C_DEPTH) ? C_DEPTH : num_psums;
  assign w_p_start = (num_passes == '0) ? C_P_ONE : num_passes;

  // Position within the row.
  assign w_last_pass = (r_pass == (r_p - C_P_ONE));
  assign w_last_idx  = ({1'b0, r_idx} == (r_n - C_N_ONE));

  // On the final pass each accepted psum goes straight out in the same
  // cycle, so the input must stall whenever the output buffer is full.
  assign w_in_ready = (r_state == S_ACCUM) && !(w_last_pass && outbuf_full);
  assign w_xfer     = in_valid && w_in_ready;
  assign w_write    = w_xfer && w_last_pass;

  // With a single pass the register file holds nothing useful, so the
  // incoming value is the finished sum.
  assign w_mem_rd = r_mem[r_idx];
  assign w_sum    = (r_p == C_P_ONE) ? in_data : wrap_add(w_mem_rd, in_data);

  assign in_ready     = w_in_ready;
  assign outbuf_write = w_write;
  assign out_data     = w_write ? w_sum : r_out_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the busy/done status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_n_start == '0) ? S_FIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        busy = 1'b1;
        if (w_xfer && w_last_idx && w_last_pass) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Row configuration and the index/pass counters; start is only honoured
  // in IDLE so a stray pulse mid-row cannot disturb an active row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx  <= '0;
      r_pass <= '0;
      r_n    <= '0;
      r_p    <= C_P_ONE;
    end else if ((r_state == S_IDLE) && start) begin
      r_idx  <= '0;
      r_pass <= '0;
      r_n    <= w_n_start;
      r_p    <= w_p_start;
    end else if (w_xfer) begin
      if (w_last_idx) begin
        r_idx  <= '0;
        r_pass <= r_pass + C_P_ONE;
      end else begin
        r_idx  <= r_idx + ADDR_LEN'(1);
      end
    end
  end

  // Partial-sum register file: pass 0 overwrites (so no clear is needed),
  // middle passes accumulate, and the final pass leaves it untouched.
  always_ff @(posedge clk) begin
    if (w_xfer && !w_last_pass) begin
      if (r_pass == '0) begin
        r_mem[r_idx] <= in_data;
      end else begin
        r_mem[r_idx] <= wrap_add(w_mem_rd, in_data);
      end
    end
  end

  // Holds the last value written so out_data stays stable between writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_q <= '0;
    end else if (w_write) begin
      r_out_q <= w_sum;
    end
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench for psum_accum_ctrl: drives inputs on the falling edge and
// checks the outputs shortly afterwards against hand-computed values.
module tb_psum_accum_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  num_psums;
  logic [3:0]  num_passes;
  logic        in_valid;
  logic [16:0] in_data;
  logic        in_ready;
  logic        outbuf_full;
  logic        outbuf_write;
  logic [16:0] out_data;
  logic        busy;
  logic        done;

  int          n_checks;
  int          n_errors;
  logic [16:0] exp_hold;

  psum_accum_ctrl #(
    .DATA_WIDTH(17),
    .ADDR_LEN  (4),
    .DEPTH     (16),
    .PASS_WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_psums   (num_psums),
    .num_passes  (num_passes),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .outbuf_full (outbuf_full),
    .outbuf_write(outbuf_write),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One datapath cycle: drive, check handshake and output, then clock.
  task automatic cyc(input string tag, input logic v, input logic [16:0] d,
                     input logic full, input logic st,
                     input logic exp_rdy, input logic exp_wr, input logic [16:0] exp_out);
    @(negedge clk);
    in_valid    = v;
    in_data     = d;
    outbuf_full = full;
    start       = st;
    #1;
    if (exp_wr) exp_hold = exp_out;
    chk({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
    chk({tag, ".wr"}, 32'(outbuf_write), 32'(exp_wr));
    chk({tag, ".out"}, 32'(out_data), 32'(exp_hold));
    @(posedge clk);
  endtask

  task automatic start_row(input string tag, input logic [4:0] n, input logic [3:0] p);
    @(negedge clk);
    in_valid    = 1'b0;
    outbuf_full = 1'b0;
    start       = 1'b1;
    num_psums   = n;
    num_passes  = p;
    #1;
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    #1;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".fin_wr"}, 32'(outbuf_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, ".done_off"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    exp_hold    = '0;
    rst         = 1'b0;
    start       = 1'b0;
    num_psums   = '0;
    num_passes  = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    outbuf_full = 1'b0;

    // Reset with random inputs held for two edges.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start       = 1'($urandom);
      num_psums   = 5'($urandom);
      num_passes  = 4'($urandom);
      in_valid    = 1'($urandom);
      in_data     = 17'($urandom);
      outbuf_full = 1'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd0);
    chk("rst.wr", 32'(outbuf_write), 32'd0);
    chk("rst.out", 32'(out_data), 32'd0);
    start = 1'b0; in_valid = 1'b0; outbuf_full = 1'b0;
    rst   = 1'b1;
    @(posedge clk);

    // Empty row: straight to the done pulse.
    start_row("n0", 5'd0, 4'd1);
    wait_done("n0");

    // Single pass: data passes straight through.
    start_row("sp", 5'd4, 4'd1);
    cyc("sp0", 1'b1, 17'd5, 1'b0, 1'b0, 1'b1, 1'b1, 17'd5);
    cyc("sp1", 1'b1, 17'd6, 1'b0, 1'b0, 1'b1, 1'b1, 17'd6);
    cyc("sp2", 1'b1, 17'd7, 1'b0, 1'b0, 1'b1, 1'b1, 17'd7);
    cyc("sp3", 1'b1, 17'd8, 1'b0, 1'b0, 1'b1, 1'b1, 17'd8);
    wait_done("sp");

    // Three passes.
    start_row("tp", 5'd3, 4'd3);
    cyc("tp00", 1'b1, 17'd1,   1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    cyc("tp01", 1'b1, 17'd2,   1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    cyc("tp02", 1'b1, 17'd3,   1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    cyc("tp10", 1'b1, 17'd10,  1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    cyc("tp11", 1'b1, 17'd20,  1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    cyc("tp12", 1'b1, 17'd30,  1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    cyc("tp20", 1'b1, 17'd100, 1'b0, 1'b0, 1'b1, 1'b1, 17'd111);
    cyc("tp21", 1'b1, 17'd200, 1'b0, 1'b0, 1'b1, 1'b1, 17'd222);
    cyc("tp22", 1'b1, 17'd300, 1'b0, 1'b0, 1'b1, 1'b1, 17'd333);
    wait_done("tp");

    // Back-pressure on the final pass.
    start_row("bp", 5'd2, 4'd2);
    cyc("bp00", 1'b1, 17'd4, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    cyc("bp01", 1'b1, 17'd4, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    for (int i = 0; i < 3; i++)
      cyc("bpfull", 1'b1, 17'd6, 1'b1, 1'b0, 1'b0, 1'b0, 17'd0);
    cyc("bp10", 1'b1, 17'd6, 1'b0, 1'b0, 1'b1, 1'b1, 17'd10);
    cyc("bp11", 1'b1, 17'd6, 1'b0, 1'b0, 1'b1, 1'b1, 17'd10);
    wait_done("bp");

    // Clamp to 16 entries, modulo wrap, stray start pulses ignored.
    start_row("wc", 5'd20, 4'd2);
    for (int i = 0; i < 16; i++)
      cyc("wc_p0", 1'b1, 17'h1FFFF, 1'b0, 1'(i % 3 == 1), 1'b1, 1'b0, 17'd0);
    for (int i = 0; i < 16; i++)
      cyc("wc_p1", 1'b1, 17'h1FFFF, 1'b0, 1'(i % 5 == 2), 1'b1, 1'b1, 17'h1FFFE);
    wait_done("wc");

    // Reset in the middle of a row.
    start_row("mr", 5'd4, 4'd2);
    for (int i = 0; i < 4; i++)
      cyc("mr_p0", 1'b1, 17'd3, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0);
    cyc("mr_p1", 1'b1, 17'd3, 1'b0, 1'b0, 1'b1, 1'b1, 17'd6);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    exp_hold = '0;
    chk("mr.busy", 32'(busy), 32'd0);
    chk("mr.rdy", 32'(in_ready), 32'd0);
    chk("mr.wr", 32'(outbuf_write), 32'd0);
    chk("mr.out", 32'(out_data), 32'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    start_row("nr", 5'd1, 4'd1);
    cyc("nr0", 1'b1, 17'd9, 1'b0, 1'b0, 1'b1, 1'b1, 17'd9);
    wait_done("nr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_accum_ctrl.md
Name: psum_accum_ctrl

Overview:
- Sits directly downstream of the PE datapath: consumes the per-output partial sums (module_outval) it produces, one filter/channel pass at a time.
- Holds one row of partial sums in an internal register file and adds each new pass onto it.
- On the final pass it streams the completed sums to the output buffer under outbuf_full back-pressure.
- Reports busy/done to the top controller.

Parameters:
- DATA_WIDTH, 17, width of one partial sum; matches module_outval width for 8-bit IF and 8-bit filter.
- ADDR_LEN, 4, index width of the psum register file.
- DEPTH, 16, number of psum entries; always equals 2**ADDR_LEN.
- PASS_WIDTH, 4, width of the pass-count input.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle pulse, begins a row; sampled only in IDLE
- num_psums  input  ADDR_LEN+1  outputs per row, latched on start
- num_passes  input  PASS_WIDTH  passes to accumulate, latched on start
- in_valid  input  1  datapath presents a psum
- in_data  input  DATA_WIDTH  psum value from datapath
- in_ready  output  1  block accepts in_data this cycle
- outbuf_full  input  1  output buffer cannot take a write
- outbuf_write  output  1  write strobe to output buffer
- out_data  output  DATA_WIDTH  completed sum to output buffer
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when a row completes

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; idx=0, pass=0.
  - in_ready=0, outbuf_write=0, out_data=0, busy=0, done=0.
  - Register-file contents are not cleared; pass 0 overwrites them.
  - Reset mid-row abandons the row with no further writes.
- Latching on start in IDLE:
  - N = num_psums, clamped to DEPTH if larger.
  - P = num_passes, with 0 treated as 1.
  - If N==0: go to FIN, emit no writes.
  - Otherwise go to ACCUM with idx=0, pass=0.
  - start in any other state is ignored.
- States:
  - IDLE: waiting for start.
  - ACCUM: accepting psums.
  - FIN: drives done=1 for exactly one cycle, then IDLE.
- Handshake:
  - Transfer = in_valid & in_ready.
  - in_ready=1 in ACCUM, except when pass==P-1 and outbuf_full==1, where in_ready=0.
  - in_ready=0 in IDLE and FIN.
  - in_valid without in_ready is held by the producer; no data is lost or duplicated.
- Per transfer at index idx:
  - pass==0 and P>1: mem[idx] <= in_data.
  - 0<pass<P-1: mem[idx] <= mem[idx] + in_data.
  - pass==P-1: nothing stored.
    - outbuf_write=1 combinationally in the same cycle.
    - out_data = (P==1) ? in_data : mem[idx] + in_data.
  - outbuf_write is never asserted while outbuf_full==1.
  - out_data holds its last value when outbuf_write==0.
- Arithmetic: unsigned add, truncated modulo 2**DATA_WIDTH; no saturation, no overflow flag.
- Counters:
  - After each transfer idx increments.
  - When idx==N-1, idx wraps to 0 and pass increments.
  - The transfer with idx==N-1 and pass==P-1 moves to FIN next cycle.
- Latency: zero cycles from final-pass transfer to outbuf_write; done rises 1 cycle after the last write.
- Simultaneous events:
  - outbuf_full rising in the same cycle as a final-pass in_valid blocks that transfer.
  - A transfer completes at the cycle where both in_valid and in_ready are 1.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> all outputs 0, busy=0; after release, start with N=0 -> done pulse 1 cycle later, no outbuf_write.
- Single pass: start N=4, P=1, in_data 5,6,7,8 back-to-back, outbuf_full=0 -> outbuf_write 4 cycles, out_data 5,6,7,8 same cycle as each transfer; done next cycle.
- Three passes: N=3, P=3; pass0 {1,2,3}, pass1 {10,20,30}, pass2 {100,200,300} -> out_data 111,222,333; no writes during passes 0-1.
- Back-pressure: N=2, P=2, pass0 {4,4}; outbuf_full=1 for 3 cycles during pass1 with in_valid=1, in_data=6 -> in_ready=0 and no write while full; then one write per transfer, out_data=10,10.
- Wrap and clamp: N=20 (clamped to 16), P=2, in_data=2**17-1 both passes -> 16 writes of 2**17-2 (modulo); start pulses mid-row ignored.
- Mid-row reset: N=4, P=2; assert rst after 5 transfers -> outbuf_write=0, state IDLE; a new row N=1, P=1, in_data=9 -> out_data=9.
